// File: rtl/rpdiag_pkg.sv
// Shared state encoding and field geometry for the RPxx drive-side diagnostic bit sequencer.
// Defining RPDIAG_SYNCTMO_EN adds the sync search timeout limit.
package rpdiag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        DATA,
        ECC
    } rpdiagState_e;

    localparam logic [4:0]  ZCNT     = 5'd16;
    localparam logic [7:0]  SYNCPAT  = 8'b0000_0001;
    localparam logic [15:0] DATABITS = 16'd9216;
    localparam logic [15:0] ECCBITS  = 16'd32;
`ifdef RPDIAG_SYNCTMO_EN
    localparam logic [15:0] SYNCTMO  = 16'd64;
`endif

endpackage

// File: rtl/rpdiag_edge.sv
// Registered rising-edge detector for the software-driven diagnostic clock, index and sector levels.
// An edge is reported one clk after the level change, and a level held high yields a single event.
module rpdiag_edge #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lvl_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] lvl_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lvl_q  <= '0;
            prev_q <= '0;
        end else begin
            lvl_q  <= lvl_i;
            prev_q <= lvl_q;
        end
    end

    assign rise_o = lvl_q & ~prev_q;

endmodule

// File: rtl/rpdiag_seq.sv
// Diagnostic bit sequencer: walks a software-clocked sector image through preamble, sync, data and ECC.
// Defining RPDIAG_SYNCTMO_EN aborts a sync search that runs too long and pulses rpSYNERR.
module rpdiag_seq
    import rpdiag_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rpDMD,
    input  logic rpDCLK,
    input  logic rpDIND,
    input  logic rpDSCK,
    input  logic rpDRDD,
    input  logic rpWDAT,
    output logic rpZD,
    output logic rpSBD,
    output logic rpDFE,
    output logic rpECE,
    output logic rpDWRD,
    output logic rpSYNERR
);

    logic [2:0]   rise;
    logic         clkRise;
    logic         sckRise;
    logic         indRise;

    rpdiagState_e state_q, state_d;
    logic [4:0]   zeroCnt_q, zeroCnt_d;
    logic [7:0]   shift_q, shift_d, shiftNext;
    logic [15:0]  bitCnt_q, bitCnt_d, bitInc;
    logic         zd_q, zd_d;
    logic         sbd_q, sbd_d;
    logic         dfe_q, dfe_d;
    logic         ece_q, ece_d;
    logic         dwrd_q, dwrd_d;
`ifdef RPDIAG_SYNCTMO_EN
    logic         synErr_q, synErr_d;
`endif

    rpdiag_edge #(.WIDTH(3)) uEdge (
        .clk    (clk),
        .rst    (rst),
        .lvl_i  ({rpDIND, rpDSCK, rpDCLK}),
        .rise_o (rise)
    );

    assign clkRise = rise[0];
    assign sckRise = rise[1];
    assign indRise = rise[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            zeroCnt_q <= '0;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            zd_q      <= 1'b0;
            sbd_q     <= 1'b0;
            dfe_q     <= 1'b0;
            ece_q     <= 1'b0;
            dwrd_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            zeroCnt_q <= zeroCnt_d;
            shift_q   <= shift_d;
            bitCnt_q  <= bitCnt_d;
            zd_q      <= zd_d;
            sbd_q     <= sbd_d;
            dfe_q     <= dfe_d;
            ece_q     <= ece_d;
            dwrd_q    <= dwrd_d;
        end
    end

`ifdef RPDIAG_SYNCTMO_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            synErr_q <= 1'b0;
        end else begin
            synErr_q <= synErr_d;
        end
    end
`endif

    // Mode drop and index share the abort path; sector beats bit clock when both arrive together.
    always_comb begin
        state_d   = state_q;
        zeroCnt_d = zeroCnt_q;
        shift_d   = shift_q;
        bitCnt_d  = bitCnt_q;
        zd_d      = zd_q;
        sbd_d     = 1'b0;
        dfe_d     = dfe_q;
        ece_d     = ece_q;
        dwrd_d    = dwrd_q;
`ifdef RPDIAG_SYNCTMO_EN
        synErr_d  = 1'b0;
`endif
        shiftNext = {shift_q[6:0], rpDRDD};
        bitInc    = bitCnt_q + 16'd1;

        if (!rpDMD || indRise) begin
            state_d = IDLE;
            zd_d    = 1'b0;
            dfe_d   = 1'b0;
            ece_d   = 1'b0;
            dwrd_d  = 1'b0;
        end else if (sckRise) begin
            state_d   = PREAMBLE;
            zeroCnt_d = '0;
            shift_d   = '0;
            bitCnt_d  = '0;
            zd_d      = 1'b0;
            dfe_d     = 1'b0;
            ece_d     = 1'b0;
            dwrd_d    = 1'b0;
        end else if (clkRise) begin
            if (dfe_q || ece_q) begin
                dwrd_d = rpWDAT;
            end
            case (state_q)
                IDLE: begin
                end
                PREAMBLE: begin
                    if (rpDRDD) begin
                        zeroCnt_d = '0;
                    end else if (zeroCnt_q < ZCNT) begin
                        zeroCnt_d = zeroCnt_q + 5'd1;
                        if (zeroCnt_q == ZCNT - 5'd1) begin
                            zd_d     = 1'b1;
                            bitCnt_d = '0;
                            state_d  = SYNC;
                        end
                    end
                end
                SYNC: begin
                    shift_d = shiftNext;
                    if (shiftNext == SYNCPAT) begin
                        sbd_d    = 1'b1;
                        zd_d     = 1'b0;
                        dfe_d    = 1'b1;
                        bitCnt_d = '0;
                        state_d  = DATA;
                    end
`ifdef RPDIAG_SYNCTMO_EN
                    else begin
                        bitCnt_d = bitInc;
                        if (bitInc == SYNCTMO) begin
                            synErr_d = 1'b1;
                            zd_d     = 1'b0;
                            state_d  = IDLE;
                        end
                    end
`endif
                end
                DATA: begin
                    bitCnt_d = bitInc;
                    if (bitInc == DATABITS) begin
                        dfe_d    = 1'b0;
                        ece_d    = 1'b1;
                        bitCnt_d = '0;
                        state_d  = ECC;
                    end
                end
                ECC: begin
                    bitCnt_d = bitInc;
                    // Leaving for IDLE drops the last ECC write bit so IDLE always reads back zero.
                    if (bitInc == ECCBITS) begin
                        ece_d   = 1'b0;
                        dwrd_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rpZD   = zd_q;
    assign rpSBD  = sbd_q;
    assign rpDFE  = dfe_q;
    assign rpECE  = ece_q;
    assign rpDWRD = dwrd_q;
`ifdef RPDIAG_SYNCTMO_EN
    assign rpSYNERR = synErr_q;
`else
    assign rpSYNERR = 1'b0;
`endif

endmodule

// File: tb/tb_rpdiag_seq.sv
// Directed-sequence bench for rpdiag_seq with random write/read data and random bit-time gaps.
// Expected outputs come from a sector-position model; RPDIAG_SYNCTMO_EN selects the timeout scenario.
module tb_rpdiag_seq;

    localparam int         ZCNT_TB     = 16;
    localparam logic [7:0] SYNCPAT_TB  = 8'b0000_0001;
    localparam int         DATABITS_TB = 9216;
    localparam int         ECCBITS_TB  = 32;
`ifdef RPDIAG_SYNCTMO_EN
    localparam int         SYNCTMO_TB  = 64;
`endif

    typedef enum int {
        STIM_BIT,
        STIM_SECTOR,
        STIM_INDEX,
        STIM_COLLIDE,
        STIM_IDLE,
        STIM_MODEOFF,
        STIM_MODEON
    } stimKind_e;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic rpDMD  = 1'b0;
    logic rpDCLK = 1'b0;
    logic rpDIND = 1'b0;
    logic rpDSCK = 1'b0;
    logic rpDRDD = 1'b0;
    logic rpWDAT = 1'b0;
    logic rpZD, rpSBD, rpDFE, rpECE, rpDWRD, rpSYNERR;

    int vectorCount = 0;
    int missCount   = 0;

    bit mMode, mActive, mZdHit, mSynced, mDwrd, mSbd, mSynErr;
    int mZeroRun, mAfter;
    bit mSyncQ[$];

    rpdiag_seq dut (
        .clk      (clk),
        .rst      (rst),
        .rpDMD    (rpDMD),
        .rpDCLK   (rpDCLK),
        .rpDIND   (rpDIND),
        .rpDSCK   (rpDSCK),
        .rpDRDD   (rpDRDD),
        .rpWDAT   (rpWDAT),
        .rpZD     (rpZD),
        .rpSBD    (rpSBD),
        .rpDFE    (rpDFE),
        .rpECE    (rpECE),
        .rpDWRD   (rpDWRD),
        .rpSYNERR (rpSYNERR)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lastEight();
        logic [7:0] v = '0;
        int first = (mSyncQ.size() > 8) ? mSyncQ.size() - 8 : 0;
        for (int i = first; i < mSyncQ.size(); i++) v = {v[6:0], mSyncQ[i]};
        return v;
    endfunction

    task automatic modelReset();
        mMode = 0; mActive = 0; mZdHit = 0; mSynced = 0;
        mDwrd = 0; mSbd = 0; mSynErr = 0; mZeroRun = 0; mAfter = 0;
        mSyncQ.delete();
    endtask

    task automatic modelSector();
        if (!mMode) return;
        mActive = 1; mZdHit = 0; mSynced = 0; mDwrd = 0; mZeroRun = 0; mAfter = 0;
        mSyncQ.delete();
    endtask

    // Position within the sector image decides every field; envelopes follow the count of post-sync bits.
    task automatic modelBit(input logic d, input logic w);
        if (!mMode || !mActive) return;
        if (!mZdHit) begin
            mZeroRun = d ? 0 : mZeroRun + 1;
            if (mZeroRun >= ZCNT_TB) mZdHit = 1;
        end else if (!mSynced) begin
            mSyncQ.push_back(d);
            if (lastEight() == SYNCPAT_TB) begin
                mSynced = 1; mSbd = 1; mAfter = 0;
            end
`ifdef RPDIAG_SYNCTMO_EN
            else if (mSyncQ.size() >= SYNCTMO_TB) begin
                mActive = 0; mSynErr = 1;
            end
`endif
        end else begin
            mDwrd  = w;
            mAfter = mAfter + 1;
            if (mAfter >= DATABITS_TB + ECCBITS_TB) mActive = 0;
        end
    endtask

    task automatic compareBit(input string tag, input logic observed, input logic expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic expZd, expDfe, expEce, expDwrd;
        expZd   = mActive && mZdHit && !mSynced;
        expDfe  = mActive && mSynced && (mAfter < DATABITS_TB);
        expEce  = mActive && mSynced && (mAfter >= DATABITS_TB);
        expDwrd = mActive && mDwrd;
        compareBit({tag, ".zd"},     rpZD,     expZd);
        compareBit({tag, ".sbd"},    rpSBD,    mSbd);
        compareBit({tag, ".dfe"},    rpDFE,    expDfe);
        compareBit({tag, ".ece"},    rpECE,    expEce);
        compareBit({tag, ".dwrd"},   rpDWRD,   expDwrd);
        compareBit({tag, ".synerr"}, rpSYNERR, mSynErr);
    endtask

    // Edge-carrying stimuli hold their level one clk, then results are checked a further clk later.
    task automatic applyStimulus(input stimKind_e kind, input logic d, input logic w, input string tag);
        mSbd = 0;
        mSynErr = 0;
        case (kind)
            STIM_BIT:     begin rpDCLK = 1; rpDRDD = d; rpWDAT = w; modelBit(d, w); end
            STIM_SECTOR:  begin rpDSCK = 1; modelSector(); end
            STIM_COLLIDE: begin rpDSCK = 1; rpDCLK = 1; rpDRDD = d; rpWDAT = w; modelSector(); end
            STIM_INDEX:   begin rpDIND = 1; if (mMode) mActive = 0; end
            STIM_MODEOFF: begin rpDMD = 0; mMode = 0; mActive = 0; end
            STIM_MODEON:  begin rpDMD = 1; mMode = 1; end
            default:      begin end
        endcase
        @(negedge clk);
        if (kind == STIM_BIT || kind == STIM_SECTOR || kind == STIM_INDEX || kind == STIM_COLLIDE) begin
            rpDCLK = 0; rpDSCK = 0; rpDIND = 0;
            @(negedge clk);
        end
        checkOutput(tag);
    endtask

    task automatic sendBit(input logic d, input string tag);
        applyStimulus(STIM_BIT, d, 1'($urandom_range(0, 1)), tag);
        if ($urandom_range(0, 3) == 0) applyStimulus(STIM_IDLE, 1'b0, 1'b0, {tag, ".gap"});
    endtask

    task automatic sendSync(input string tag);
        for (int i = 7; i >= 0; i--) sendBit(SYNCPAT_TB[i], tag);
    endtask

    initial begin
        modelReset();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rpDMD  = 1'($urandom_range(0, 1));
            rpDCLK = 1'($urandom_range(0, 1));
            rpDIND = 1'($urandom_range(0, 1));
            rpDSCK = 1'($urandom_range(0, 1));
            rpDRDD = 1'($urandom_range(0, 1));
            rpWDAT = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        {rpDMD, rpDCLK, rpDIND, rpDSCK, rpDRDD, rpWDAT} = '0;
        @(negedge clk);
        checkOutput("reset.held");
        rst = 1;
        applyStimulus(STIM_IDLE, 1'b0, 1'b0, "reset.release");
        applyStimulus(STIM_MODEON, 1'b0, 1'b0, "reset.modeon");
        for (int i = 0; i < 20; i++) sendBit(1'b0, "reset.idlebits");

        $display("[TB] normal sector");
        applyStimulus(STIM_SECTOR, 1'b0, 1'b0, "normal.sector");
        for (int i = 0; i < ZCNT_TB; i++) sendBit(1'b0, "normal.preamble");
        for (int i = 7; i >= 0; i--) applyStimulus(STIM_BIT, SYNCPAT_TB[i], 1'($urandom_range(0, 1)), "normal.sync");
        applyStimulus(STIM_IDLE, 1'b0, 1'b0, "normal.sbdpulse");
        for (int i = 0; i < DATABITS_TB; i++) sendBit(1'($urandom_range(0, 1)), "normal.data");
        for (int i = 0; i < ECCBITS_TB; i++) sendBit(1'($urandom_range(0, 1)), "normal.ecc");
        for (int i = 0; i < 4; i++) sendBit(1'($urandom_range(0, 1)), "normal.after");

        $display("[TB] broken preamble");
        applyStimulus(STIM_SECTOR, 1'b0, 1'b0, "broken.sector");
        for (int i = 0; i < 10; i++) sendBit(1'b0, "broken.zeros10");
        sendBit(1'b1, "broken.one");
        for (int i = 0; i < ZCNT_TB; i++) sendBit(1'b0, "broken.zeros16");
        sendSync("broken.sync");

        $display("[TB] random preamble and index abort");
        applyStimulus(STIM_SECTOR, 1'b0, 1'b0, "abort.sector");
        for (int i = 0; i < 60 && !mZdHit; i++) sendBit(1'($urandom_range(0, 3) == 0), "abort.randpre");
        for (int i = 0; i < ZCNT_TB && !mZdHit; i++) sendBit(1'b0, "abort.preamble");
        sendSync("abort.sync");
        for (int i = 0; i < 100; i++) sendBit(1'($urandom_range(0, 1)), "abort.data");
        applyStimulus(STIM_INDEX, 1'b0, 1'b0, "abort.index");
        for (int i = 0; i < 6; i++) sendBit(1'b0, "abort.after");

        $display("[TB] sector and bit collision, then mode drop in ECC");
        applyStimulus(STIM_SECTOR, 1'b0, 1'b0, "collide.sector");
        for (int i = 0; i < 10; i++) sendBit(1'b0, "collide.zeros10");
        applyStimulus(STIM_COLLIDE, 1'b0, 1'($urandom_range(0, 1)), "collide.edge");
        for (int i = 0; i < ZCNT_TB; i++) sendBit(1'b0, "collide.zeros16");
        sendSync("collide.sync");
        for (int i = 0; i < DATABITS_TB; i++) sendBit(1'($urandom_range(0, 1)), "collide.data");
        for (int i = 0; i < 10; i++) sendBit(1'($urandom_range(0, 1)), "collide.ecc");
        applyStimulus(STIM_MODEOFF, 1'b0, 1'b0, "modedrop.off");
        for (int i = 0; i < 3; i++) sendBit(1'b0, "modedrop.bits");
        applyStimulus(STIM_SECTOR, 1'b0, 1'b0, "modedrop.sector");
        applyStimulus(STIM_MODEON, 1'b0, 1'b0, "modedrop.on");
        for (int i = 0; i < 20; i++) sendBit(1'b0, "modedrop.after");

`ifdef RPDIAG_SYNCTMO_EN
        $display("[TB] sync timeout");
        applyStimulus(STIM_SECTOR, 1'b0, 1'b0, "tmo.sector");
        for (int i = 0; i < ZCNT_TB; i++) sendBit(1'b0, "tmo.preamble");
        for (int i = 0; i < SYNCTMO_TB - 1; i++) sendBit(1'b1, "tmo.ones");
        applyStimulus(STIM_BIT, 1'b1, 1'b0, "tmo.last");
        applyStimulus(STIM_IDLE, 1'b0, 1'b0, "tmo.pulseend");
        for (int i = 0; i < 10; i++) sendBit(1'b0, "tmo.after");
`else
        $display("[TB] long sync search");
        applyStimulus(STIM_SECTOR, 1'b0, 1'b0, "search.sector");
        for (int i = 0; i < ZCNT_TB; i++) sendBit(1'b0, "search.preamble");
        for (int i = 0; i < 70; i++) sendBit(1'b1, "search.ones");
        sendSync("search.sync");
        for (int i = 0; i < 5; i++) sendBit(1'($urandom_range(0, 1)), "search.data");
        applyStimulus(STIM_INDEX, 1'b0, 1'b0, "search.index");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
